// File: rtl/gl_prim_if.sv
// Vertex-in / triangle-out bundle between the vertex source, gl_prim_assembler and gl_rasterizer.
// Vertex transfer: vtx_in is taken at a posedge only when vtx_valid and vtx_ready are both high.
interface gl_prim_if #(
  parameter int W  = 96,
  parameter int AW = 3
);
  logic [W-1:0]  vtx_in;
  logic          vtx_valid;
  logic          vtx_ready;
  logic [W-1:0]  fifo_out1;
  logic [W-1:0]  fifo_out2;
  logic [W-1:0]  fifo_out3;
  logic          fifo_ready;
  logic          raster_ready;
  logic          busy;
  logic [AW:0]   fifo_level;
  logic [15:0]   tri_count;
  logic [1:0]    state_dbg;

  modport slave (
    input  vtx_in, vtx_valid, raster_ready,
    output vtx_ready, fifo_out1, fifo_out2, fifo_out3, fifo_ready,
           busy, fifo_level, tri_count, state_dbg
  );

  modport master (
    output vtx_in, vtx_valid, raster_ready,
    input  vtx_ready, fifo_out1, fifo_out2, fifo_out3, fifo_ready,
           busy, fifo_level, tri_count, state_dbg
  );
endinterface

// File: rtl/gl_prim_assembler.sv
// Buffers incoming vertices, groups every three into a triangle and holds it
// stable on fifo_out1..3 until the rasterizer's completion edge.
module gl_prim_assembler #(
  parameter int VERTEX_TYPE_SIZE = 96,
  parameter int DEPTH            = 8,
  parameter int AW               = 3
) (
  input  logic      clk,
  input  logic      rst,
  gl_prim_if.slave  bus
);
  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    ISSUE   = 2'd1,
    BUSY    = 2'd2
  } state_t;

  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [VERTEX_TYPE_SIZE-1:0] mem [DEPTH];
  logic [AW-1:0]               wr_ptr, rd_ptr;
  logic [AW:0]                 level;
  logic [1:0]                  slot_k;
  logic                        rr_q;
  logic [15:0]                 tri_q;
  logic [VERTEX_TYPE_SIZE-1:0] out1_q, out2_q, out3_q;
  state_t                      state_q, state_d;

  logic full, empty, push, pop, rise;

  assign full  = (level == FULL_LEVEL);
  assign empty = (level == '0);
  // A full FIFO refuses the push even if a pop happens in the same cycle.
  assign push  = bus.vtx_valid && !full;
  assign pop   = (state_q == COLLECT) && !empty;
  assign rise  = bus.raster_ready && !rr_q;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.vtx_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      slot_k  <= '0;
      rr_q    <= 1'b0;
      tri_q   <= '0;
      out1_q  <= '0;
      out2_q  <= '0;
      out3_q  <= '0;
    end else begin
      rr_q <= bus.raster_ready;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        case (slot_k)
          2'd0:    out1_q <= mem[rd_ptr];
          2'd1:    out2_q <= mem[rd_ptr];
          default: out3_q <= mem[rd_ptr];
        endcase
        slot_k <= (slot_k == 2'd2) ? 2'd0 : slot_k + 2'd1;
      end
      case ({push, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
      if (state_q == BUSY && rise) tri_q <= tri_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= COLLECT;
    else     state_q <= state_d;
  end

  // Edges arriving outside BUSY are dropped; only BUSY watches for completion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (pop && slot_k == 2'd2) state_d = ISSUE;
      ISSUE:   state_d = BUSY;
      BUSY:    if (rise) state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  assign bus.vtx_ready  = !full;
  assign bus.fifo_out1  = out1_q;
  assign bus.fifo_out2  = out2_q;
  assign bus.fifo_out3  = out3_q;
  assign bus.fifo_ready = (state_q == ISSUE);
  assign bus.busy       = (state_q != COLLECT);
  assign bus.fifo_level = level;
  assign bus.tri_count  = tri_q;
  assign bus.state_dbg  = state_q;
endmodule

// File: tb/tb_gl_prim_assembler.sv
// Bench for gl_prim_assembler: accepted vertices go into an ordered queue and
// every fifo_ready pulse must present the next three of them.
module tb_gl_prim_assembler;
  localparam int W = 96;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gl_prim_if #(.W(W), .AW(AW)) bus ();

  gl_prim_assembler #(.VERTEX_TYPE_SIZE(W), .DEPTH(8), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [W-1:0] exp_q[$];
  int           checks = 0;
  int           failures = 0;
  int           exp_tri = 0;
  logic [W-1:0] held1 = '0, held2 = '0, held3 = '0;
  logic [W-1:0] e1, e2, e3;
  logic         prev_fr = 1'b0;

  // Scoreboard: each triangle is the next three accepted vertices, held stable while busy.
  always @(negedge clk) begin
    if (rst) begin
      prev_fr = 1'b0;
    end else begin
      if (bus.fifo_ready) begin
        checks++;
        if (prev_fr) begin
          failures++;
          $display("FAIL pulse_width fifo_ready high in two consecutive cycles");
        end
        checks++;
        if (exp_q.size() < 3) begin
          failures++;
          $display("FAIL underrun triangle issued with only %0d expected vertices queued", exp_q.size());
        end else begin
          e1 = exp_q.pop_front();
          e2 = exp_q.pop_front();
          e3 = exp_q.pop_front();
          held1 = e1; held2 = e2; held3 = e3;
          if (bus.fifo_out1 !== e1 || bus.fifo_out2 !== e2 || bus.fifo_out3 !== e3) begin
            failures++;
            $display("FAIL triangle got %h %h %h expected %h %h %h",
                     bus.fifo_out1, bus.fifo_out2, bus.fifo_out3, e1, e2, e3);
          end
        end
      end else if (bus.busy) begin
        checks++;
        if (bus.fifo_out1 !== held1 || bus.fifo_out2 !== held2 || bus.fifo_out3 !== held3) begin
          failures++;
          $display("FAIL hold_stable got %h %h %h expected %h %h %h",
                   bus.fifo_out1, bus.fifo_out2, bus.fifo_out3, held1, held2, held3);
        end
      end
      prev_fr = bus.fifo_ready;
    end
  end

  function automatic logic [W-1:0] rand_vtx();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  // Call away from a posedge; returns 1ns after the accepting edge.
  task automatic push_vtx(input logic [W-1:0] v);
    int n = 0;
    bus.vtx_in = v;
    bus.vtx_valid = 1'b1;
    while (!bus.vtx_ready && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.vtx_ready) begin
      checks++; failures++;
      $display("FAIL push_timeout vtx_ready stayed 0 for %0d cycles, expected 1", n);
    end else begin
      @(posedge clk);
      exp_q.push_back(v);
      #1;
    end
    bus.vtx_valid = 1'b0;
  endtask

  task automatic wait_busy();
    int n = 0;
    @(negedge clk);
    while (!(bus.busy && !bus.fifo_ready) && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(bus.busy && !bus.fifo_ready)) begin
      failures++;
      $display("FAIL wait_busy busy=%0b after %0d cycles, expected 1", bus.busy, n);
    end
  endtask

  // One clean 0->1->0 completion pulse; caller ensures the block is in BUSY.
  task automatic complete();
    @(negedge clk);
    bus.raster_ready = 1'b1;
    exp_tri++;
    @(negedge clk);
    bus.raster_ready = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((bus.busy || exp_q.size() >= 3) && n < 50) begin
      wait_busy();
      complete();
      n++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.vtx_valid = 1'b0;
    bus.raster_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    exp_tri = 0;
    held1 = '0; held2 = '0; held3 = '0;
  endtask

  task automatic test_reset();
    bus.vtx_in = rand_vtx();
    bus.vtx_valid = 1'b0;
    bus.raster_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.fifo_ready !== 1'b0 || bus.busy !== 1'b0 || bus.fifo_out1 !== '0 ||
        bus.fifo_out2 !== '0 || bus.fifo_out3 !== '0 || bus.fifo_level !== '0 || bus.tri_count !== '0) begin
      failures++;
      $display("FAIL reset_outputs got fr=%0b busy=%0b lvl=%0d tri=%0d out1=%h expected all 0",
               bus.fifo_ready, bus.busy, bus.fifo_level, bus.tri_count, bus.fifo_out1);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.vtx_ready !== 1'b1 || bus.state_dbg !== 2'd0) begin
      failures++;
      $display("FAIL reset_ready got vtx_ready=%0b state=%0d expected 1 and 0", bus.vtx_ready, bus.state_dbg);
    end
  endtask

  task automatic test_first_triangle();
    logic [W-1:0] v [3];
    for (int i = 0; i < 3; i++) v[i] = rand_vtx();
    for (int i = 0; i < 3; i++) push_vtx(v[i]);
    @(negedge clk);
    checks++;
    if (bus.fifo_ready !== 1'b0) begin
      failures++;
      $display("FAIL latency_early fifo_ready=%0b one edge after V2, expected 0", bus.fifo_ready);
    end
    @(negedge clk);
    checks++;
    if (bus.fifo_ready !== 1'b1 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL latency_issue got fr=%0b busy=%0b expected 1 1", bus.fifo_ready, bus.busy);
    end
    checks++;
    if (bus.fifo_out1 !== v[0] || bus.fifo_out2 !== v[1] || bus.fifo_out3 !== v[2]) begin
      failures++;
      $display("FAIL first_tri got %h %h %h expected %h %h %h",
               bus.fifo_out1, bus.fifo_out2, bus.fifo_out3, v[0], v[1], v[2]);
    end
    @(negedge clk);
    checks++;
    if (bus.fifo_ready !== 1'b0 || bus.busy !== 1'b1 || bus.fifo_level !== '0) begin
      failures++;
      $display("FAIL pulse_end got fr=%0b busy=%0b lvl=%0d expected 0 1 0", bus.fifo_ready, bus.busy, bus.fifo_level);
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 8; i++) push_vtx(rand_vtx());
    @(negedge clk);
    checks++;
    if (bus.vtx_ready !== 1'b0 || int'(bus.fifo_level) != exp_q.size()) begin
      failures++;
      $display("FAIL full got vtx_ready=%0b lvl=%0d expected 0 and %0d", bus.vtx_ready, bus.fifo_level, exp_q.size());
    end
    fork
      push_vtx(rand_vtx());
      begin
        repeat (4) @(negedge clk);
        checks++;
        if (bus.vtx_ready !== 1'b0 || bus.busy !== 1'b1) begin
          failures++;
          $display("FAIL stall got vtx_ready=%0b busy=%0b expected 0 1", bus.vtx_ready, bus.busy);
        end
        complete();
        checks++;
        if (bus.busy !== 1'b0 || int'(bus.tri_count) != exp_tri) begin
          failures++;
          $display("FAIL completion got busy=%0b tri=%0d expected 0 %0d", bus.busy, bus.tri_count, exp_tri);
        end
      end
    join
    wait_busy();
    checks++;
    if (int'(bus.fifo_level) != exp_q.size()) begin
      failures++;
      $display("FAIL level_busy got %0d expected %0d", bus.fifo_level, exp_q.size());
    end
    drain();
    @(negedge clk);
    checks++;
    if (int'(bus.tri_count) != exp_tri || exp_q.size() != 0 || bus.fifo_level !== '0) begin
      failures++;
      $display("FAIL drain got tri=%0d lvl=%0d expected %0d 0 (queue %0d)",
               bus.tri_count, bus.fifo_level, exp_tri, exp_q.size());
    end
  endtask

  task automatic test_held_high();
    for (int i = 0; i < 3; i++) push_vtx(rand_vtx());
    wait_busy();
    @(negedge clk);
    bus.raster_ready = 1'b1;
    exp_tri++;
    @(negedge clk);
    checks++;
    if (int'(bus.tri_count) != exp_tri || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL held_first got tri=%0d busy=%0b expected %0d 0", bus.tri_count, bus.busy, exp_tri);
    end
    for (int i = 0; i < 3; i++) push_vtx(rand_vtx());
    wait_busy();
    repeat (6) @(negedge clk);
    checks++;
    if (int'(bus.tri_count) != exp_tri || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL held_level got tri=%0d busy=%0b expected %0d 1", bus.tri_count, bus.busy, exp_tri);
    end
    bus.raster_ready = 1'b0;
    @(negedge clk);
    bus.raster_ready = 1'b1;
    exp_tri++;
    @(negedge clk);
    bus.raster_ready = 1'b0;
    checks++;
    if (int'(bus.tri_count) != exp_tri || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL held_reedge got tri=%0d busy=%0b expected %0d 0", bus.tri_count, bus.busy, exp_tri);
    end
  endtask

  task automatic test_reset_mid();
    push_vtx(rand_vtx());
    push_vtx(rand_vtx());
    do_reset();
    checks++;
    if (bus.fifo_out1 !== '0 || bus.fifo_out2 !== '0 || bus.fifo_level !== '0 ||
        bus.tri_count !== '0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_partial got out1=%h lvl=%0d tri=%0d busy=%0b expected 0",
               bus.fifo_out1, bus.fifo_level, bus.tri_count, bus.busy);
    end
    for (int i = 0; i < 3; i++) push_vtx(rand_vtx());
    wait_busy();
    checks++;
    if (bus.fifo_level !== '0 || bus.tri_count !== '0) begin
      failures++;
      $display("FAIL reset_refill got lvl=%0d tri=%0d expected 0 0", bus.fifo_level, bus.tri_count);
    end
    do_reset();
    checks++;
    if (bus.busy !== 1'b0 || bus.fifo_ready !== 1'b0 || bus.fifo_out3 !== '0) begin
      failures++;
      $display("FAIL reset_raster got busy=%0b fr=%0b out3=%h expected 0", bus.busy, bus.fifo_ready, bus.fifo_out3);
    end
  endtask

  task automatic test_push_pop_level4();
    for (int i = 0; i < 3; i++) push_vtx(rand_vtx());
    wait_busy();
    for (int i = 0; i < 4; i++) push_vtx(rand_vtx());
    complete();
    for (int i = 0; i < 3; i++) begin
      push_vtx(rand_vtx());
      checks++;
      if (bus.fifo_level !== 4'd4) begin
        failures++;
        $display("FAIL level4 cycle %0d got %0d expected 4", i, bus.fifo_level);
      end
    end
    push_vtx(rand_vtx());
    push_vtx(rand_vtx());
    drain();
  endtask

  task automatic test_random_stream();
    fork
      for (int i = 0; i < 30; i++) begin
        push_vtx(rand_vtx());
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
      for (int t = 0; t < 10; t++) begin
        wait_busy();
        repeat ($urandom_range(0, 5)) @(negedge clk);
        complete();
      end
    join
    @(negedge clk);
    checks++;
    if (int'(bus.tri_count) != exp_tri || exp_q.size() != 0 || bus.fifo_level !== '0) begin
      failures++;
      $display("FAIL stream got tri=%0d lvl=%0d queue=%0d expected %0d 0 0",
               bus.tri_count, bus.fifo_level, exp_q.size(), exp_tri);
    end
  endtask

  task automatic test_tri_wrap();
    @(negedge clk);
    force dut.tri_q = 16'hFFFF;
    #1;
    release dut.tri_q;
    for (int i = 0; i < 3; i++) push_vtx(rand_vtx());
    wait_busy();
    complete();
    checks++;
    if (bus.tri_count !== 16'h0000) begin
      failures++;
      $display("FAIL tri_wrap got %h expected 0000", bus.tri_count);
    end
  endtask

  initial begin
    test_reset();
    test_first_triangle();
    test_backpressure();
    test_held_high();
    test_reset_mid();
    test_push_pop_level4();
    test_random_stream();
    test_tri_wrap();
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
